// File: rtl/alu_exec_sequencer_if.sv
// Instruction channel into the ALU execution sequencer: one
// register-to-register instruction per valid/ready handshake.
interface alu_exec_sequencer_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_dst;
    logic [2:0] instr_srca;
    logic [2:0] instr_srcb;
    logic       instr_usec;

    modport master (
        output instr_valid, instr_op, instr_dst, instr_srca, instr_srcb, instr_usec,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_dst, instr_srca, instr_srcb, instr_usec,
        output instr_ready
    );
endinterface

// File: rtl/alu_exec_sequencer.sv
// Sequencer feeding a combinational 8-bit ALU: latches one instruction,
// presents operands from an 8x8 register file for one EXEC cycle, then
// writes the ALU result back and updates the carry flag.
module alu_exec_sequencer #(
    parameter int REGS = 8,
    parameter int W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_exec_sequencer_if.slave  req,
    input  logic                 load_en,
    input  logic [2:0]           load_addr,
    input  logic [W-1:0]         load_data,
    input  logic [2:0]           rd_addr,
    output logic [W-1:0]         rd_data,
    output logic [W-1:0]         alu_opA,
    output logic [W-1:0]         alu_opB,
    output logic [3:0]           alu_opcode,
    output logic                 alu_cin,
    input  logic [W-1:0]         alu_result,
    input  logic                 alu_cout,
    output logic                 done,
    output logic [W-1:0]         result,
    output logic                 carry_flag
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] dst;
        logic [2:0] srca;
        logic [2:0] srcb;
        logic       usec;
    } instr_t;

    state_t                  state;
    instr_t                  iq;
    logic [REGS-1:0][W-1:0]  rf;

    // Ready only while idle and out of reset, so an accept can never
    // coincide with the reset edge.
    assign req.instr_ready = (state == IDLE) && !rst;

    // Debug read port and ALU drive, combinational from latched fields.
    assign rd_data    = rf[rd_addr];
    assign alu_opA    = rf[iq.srca];
    assign alu_opB    = rf[iq.srcb];
    assign alu_opcode = iq.op;
    assign alu_cin    = iq.usec & carry_flag;

    // Control FSM, register file and writeback state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            iq         <= '0;
            rf         <= '0;
            result     <= '0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A load alongside an accept lands before EXEC reads the file.
                    if (load_en)
                        rf[load_addr] <= load_data;
                    if (req.instr_valid) begin
                        iq.op   <= req.instr_op;
                        iq.dst  <= req.instr_dst;
                        iq.srca <= req.instr_srca;
                        iq.srcb <= req.instr_srcb;
                        iq.usec <= req.instr_usec;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands were sampled from the pre-writeback file, so
                    // dst aliasing a source is harmless.
                    rf[iq.dst] <= alu_result;
                    result     <= alu_result;
                    carry_flag <= alu_cout;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: models the downstream ALU, keeps an
// architectural register-file model, and checks directed and random runs.
module tb_alu_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [2:0] load_addr;
    logic [7:0] load_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_opA, alu_opB, alu_result;
    logic [3:0] alu_opcode;
    logic       alu_cin, alu_cout;
    logic       done, carry_flag;
    logic [7:0] result;

    alu_exec_sequencer_if iif();

    alu_exec_sequencer dut (
        .clk(clk), .rst(rst), .req(iif),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .done(done), .result(result), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    // Behaviour of the 8-bit ALU: {cout, result}; carry only from ADD.
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd1: return {1'b0, 8'(a - b)};
            4'd2: return {1'b0, a[6:0], cin};
            4'd3: return {1'b0, cin, a[7:1]};
            4'd4: return {1'b0, a ^ b};
            4'd5: return (a == b) ? 9'd1 : ((a > b) ? 9'd2 : 9'd3);
            4'd6: return {1'b0, a & b};
            4'd7: return {1'b0, ~(a & b)};
            4'd8: return {1'b0, a | b};
            4'd9: return {1'b0, ~(a | b)};
            default: return 9'd0;
        endcase
    endfunction

    always_comb {alu_cout, alu_result} = alu_ref(alu_opcode, alu_opA, alu_opB, alu_cin);

    // Architectural model and counters
    logic [7:0] ref_rf [8];
    logic       ref_carry;
    logic [7:0] ref_result;
    int         chk = 0;
    int         pass = 0;

    // Observations captured by run_instr
    logic [7:0] e_opA, e_opB, o_opA, o_opB, o_result, o_rd;
    logic [3:0] o_opc;
    logic       e_cin, o_cin, o_done_exec, o_done, o_done_after;
    logic       o_ready_acc, o_ready_done, o_ready_after, o_carry;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
        ref_carry  = 1'b0;
        ref_result = 8'h00;
    endtask

    // Single register load while idle
    task automatic do_load(input logic [2:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        ref_rf[a] = d;
    endtask

    // Issue one instruction from IDLE (optionally with a same-cycle load)
    // and capture what happens across EXEC, DONE and the return to IDLE.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sa,
                             input logic [2:0] sb, input logic usec, input logic ld,
                             input logic [2:0] la, input logic [7:0] ldd);
        iif.instr_valid = 1'b1; iif.instr_op = op; iif.instr_dst = dst;
        iif.instr_srca = sa; iif.instr_srcb = sb; iif.instr_usec = usec;
        load_en = ld; load_addr = la; load_data = ldd;
        o_ready_acc = iif.instr_ready;
        if (ld) ref_rf[la] = ldd;
        e_opA = ref_rf[sa];
        e_opB = ref_rf[sb];
        e_cin = usec & ref_carry;
        {ref_carry, ref_result} = alu_ref(op, e_opA, e_opB, e_cin);
        @(posedge clk); #1;
        iif.instr_valid = 1'b0; load_en = 1'b0;
        iif.instr_op = 4'($urandom); iif.instr_dst = 3'($urandom);
        iif.instr_srca = 3'($urandom); iif.instr_srcb = 3'($urandom);
        o_opA = alu_opA; o_opB = alu_opB; o_opc = alu_opcode; o_cin = alu_cin;
        o_done_exec = done;
        rd_addr = dst;
        @(posedge clk); #1;
        ref_rf[dst] = ref_result;
        o_done = done; o_ready_done = iif.instr_ready;
        o_result = result; o_carry = carry_flag; o_rd = rd_data;
        @(posedge clk); #1;
        o_done_after = done; o_ready_after = iif.instr_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; rd_addr = '0;
        iif.instr_valid = 1'b0; iif.instr_op = '0; iif.instr_dst = '0;
        iif.instr_srca = '0; iif.instr_srcb = '0; iif.instr_usec = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk++; if (iif.instr_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", iif.instr_ready); else pass++;
        chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else pass++;
        chk++; if (result !== 8'h00) $display("FAIL rst_result: got %h exp 00", result); else pass++;
        chk++; if (carry_flag !== 1'b0) $display("FAIL rst_carry: got %b exp 0", carry_flag); else pass++;
        chk++; if (alu_opcode !== 4'h0) $display("FAIL rst_opcode: got %h exp 0", alu_opcode); else pass++;
        chk++; if (alu_opA !== 8'h00 || alu_opB !== 8'h00) $display("FAIL rst_ops: got %h/%h exp 00/00", alu_opA, alu_opB); else pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        chk++; if (iif.instr_ready !== 1'b1) $display("FAIL rst_ready_after: got %b exp 1", iif.instr_ready); else pass++;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            chk++; if (rd_data !== 8'h00) $display("FAIL rst_rf%0d: got %h exp 00", i, rd_data); else pass++;
        end
    endtask

    task automatic test_add_sub();
        do_load(3'd1, 8'hF0);
        do_load(3'd2, 8'h20);
        run_instr(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00);
        chk++; if (o_done_exec !== 1'b0 || o_done !== 1'b1 || o_done_after !== 1'b0)
            $display("FAIL add_done_timing: got %b%b%b exp 010", o_done_exec, o_done, o_done_after); else pass++;
        chk++; if (o_result !== 8'h10 || o_carry !== 1'b1) $display("FAIL add_result: got %h c%b exp 10 c1", o_result, o_carry); else pass++;
        chk++; if (o_rd !== 8'h10) $display("FAIL add_r3: got %h exp 10", o_rd); else pass++;
        chk++; if (o_ready_done !== 1'b0 || o_ready_after !== 1'b1)
            $display("FAIL add_ready: got %b%b exp 01", o_ready_done, o_ready_after); else pass++;
        run_instr(4'd0, 3'd4, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00);
        chk++; if (o_cin !== 1'b1) $display("FAIL addc_cin: got %b exp 1", o_cin); else pass++;
        chk++; if (o_rd !== 8'h11 || o_carry !== 1'b1) $display("FAIL addc_r4: got %h c%b exp 11 c1", o_rd, o_carry); else pass++;
        run_instr(4'd1, 3'd5, 3'd2, 3'd1, 1'b0, 1'b0, 3'd0, 8'h00);
        chk++; if (o_rd !== 8'h30 || o_carry !== 1'b0) $display("FAIL sub_r5: got %h c%b exp 30 c0", o_rd, o_carry); else pass++;
    endtask

    task automatic test_cmp();
        run_instr(4'd5, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00);
        chk++; if (o_rd !== 8'h02) $display("FAIL cmp_gt: got %h exp 02", o_rd); else pass++;
        run_instr(4'd5, 3'd6, 3'd2, 3'd1, 1'b0, 1'b0, 3'd0, 8'h00);
        chk++; if (o_rd !== 8'h03) $display("FAIL cmp_lt: got %h exp 03", o_rd); else pass++;
        run_instr(4'd5, 3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0, 8'h00);
        chk++; if (o_rd !== 8'h01) $display("FAIL cmp_eq: got %h exp 01", o_rd); else pass++;
        // Set carry first so the illegal opcode visibly clears it.
        run_instr(4'd0, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00);
        run_instr(4'hC, 3'd7, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 8'h00);
        chk++; if (o_opc !== 4'hC) $display("FAIL opc_c_opcode: got %h exp c", o_opc); else pass++;
        chk++; if (o_rd !== 8'h00 || o_carry !== 1'b0) $display("FAIL opc_c: got %h c%b exp 00 c0", o_rd, o_carry); else pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3] = '{4'd0, 4'd4, 4'd8};
        logic [2:0] dsts [3] = '{3'd2, 3'd3, 3'd4};
        logic [2:0] sas [3] = '{3'd1, 3'd2, 3'd3};
        logic [2:0] sbs [3] = '{3'd5, 3'd1, 3'd2};
        int acc_cyc [3] = '{-1, -1, -1};
        int k = 0;
        logic acc;
        iif.instr_valid = 1'b1; iif.instr_op = ops[0]; iif.instr_dst = dsts[0];
        iif.instr_srca = sas[0]; iif.instr_srcb = sbs[0]; iif.instr_usec = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            acc = iif.instr_ready && iif.instr_valid;
            if (acc) begin
                e_cin = ref_carry;
                {ref_carry, ref_result} = alu_ref(ops[k], ref_rf[sas[k]], ref_rf[sbs[k]], e_cin);
                ref_rf[dsts[k]] = ref_result;
            end
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 3) begin
                    iif.instr_op = ops[k]; iif.instr_dst = dsts[k];
                    iif.instr_srca = sas[k]; iif.instr_srcb = sbs[k];
                end else begin
                    iif.instr_valid = 1'b0;
                end
            end
        end
        chk++; if (acc_cyc[0] !== 0 || acc_cyc[1] !== 3 || acc_cyc[2] !== 6)
            $display("FAIL b2b_accepts: got %0d,%0d,%0d exp 0,3,6", acc_cyc[0], acc_cyc[1], acc_cyc[2]); else pass++;
        for (int i = 0; i < 3; i++) begin
            rd_addr = dsts[i]; #1;
            chk++; if (rd_data !== ref_rf[dsts[i]]) $display("FAIL b2b_r%0d: got %h exp %h", dsts[i], rd_data, ref_rf[dsts[i]]); else pass++;
        end
        chk++; if (carry_flag !== ref_carry) $display("FAIL b2b_carry: got %b exp %b", carry_flag, ref_carry); else pass++;
    endtask

    task automatic test_load_ignored();
        do_load(3'd7, 8'h11);
        iif.instr_valid = 1'b1; iif.instr_op = 4'd4; iif.instr_dst = 3'd0;
        iif.instr_srca = 3'd7; iif.instr_srcb = 3'd7; iif.instr_usec = 1'b0;
        {ref_carry, ref_result} = alu_ref(4'd4, ref_rf[7], ref_rf[7], 1'b0);
        ref_rf[0] = ref_result;
        @(posedge clk); #1;
        iif.instr_valid = 1'b0;
        load_en = 1'b1; load_addr = 3'd7; load_data = 8'h5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        load_en = 1'b0;
        rd_addr = 3'd7; #1;
        chk++; if (rd_data !== 8'h11) $display("FAIL load_in_exec: got %h exp 11", rd_data); else pass++;
        rd_addr = 3'd0; #1;
        chk++; if (rd_data !== 8'h00) $display("FAIL xor_self_r0: got %h exp 00", rd_data); else pass++;
    endtask

    task automatic test_reset_abort();
        do_load(3'd3, 8'h77);
        iif.instr_valid = 1'b1; iif.instr_op = 4'd0; iif.instr_dst = 3'd3;
        iif.instr_srca = 3'd1; iif.instr_srcb = 3'd2; iif.instr_usec = 1'b0;
        @(posedge clk); #1;
        iif.instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk++; if (done !== 1'b0) $display("FAIL abort_done: got %b exp 0", done); else pass++;
        chk++; if (iif.instr_ready !== 1'b0) $display("FAIL abort_ready_in_rst: got %b exp 0", iif.instr_ready); else pass++;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk++; if (done !== 1'b0) $display("FAIL abort_done_late: got %b exp 0", done); else pass++;
        chk++; if (iif.instr_ready !== 1'b1) $display("FAIL abort_ready_after: got %b exp 1", iif.instr_ready); else pass++;
        rd_addr = 3'd3; #1;
        chk++; if (rd_data !== 8'h00 || carry_flag !== 1'b0) $display("FAIL abort_r3: got %h c%b exp 00 c0", rd_data, carry_flag); else pass++;
    endtask

    task automatic test_load_accept();
        do_load(3'd1, 8'hF0);
        do_load(3'd2, 8'h20);
        run_instr(4'd0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h00);
        chk++; if (o_carry !== 1'b1) $display("FAIL la_setup_carry: got %b exp 1", o_carry); else pass++;
        run_instr(4'd2, 3'd6, 3'd6, 3'd0, 1'b1, 1'b1, 3'd6, 8'h81);
        chk++; if (o_opA !== 8'h81) $display("FAIL la_opA: got %h exp 81", o_opA); else pass++;
        chk++; if (o_rd !== 8'h03 || o_carry !== 1'b0) $display("FAIL la_r6: got %h c%b exp 03 c0", o_rd, o_carry); else pass++;
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [2:0] d, a, b, la;
        logic       u, ld;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) do_load(3'($urandom), 8'($urandom));
            op = 4'($urandom_range(0, 15)); d = 3'($urandom); a = 3'($urandom); b = 3'($urandom);
            u = 1'($urandom); ld = ($urandom_range(0, 3) == 0); la = 3'($urandom);
            run_instr(op, d, a, b, u, ld, la, 8'($urandom));
            chk++; if (o_ready_acc !== 1'b1) $display("FAIL rnd%0d_ready: got %b exp 1", n, o_ready_acc); else pass++;
            chk++; if (o_opA !== e_opA || o_opB !== e_opB) $display("FAIL rnd%0d_ops: got %h/%h exp %h/%h", n, o_opA, o_opB, e_opA, e_opB); else pass++;
            chk++; if (o_opc !== op || o_cin !== e_cin) $display("FAIL rnd%0d_opc_cin: got %h/%b exp %h/%b", n, o_opc, o_cin, op, e_cin); else pass++;
            chk++; if (o_done_exec !== 1'b0 || o_done !== 1'b1 || o_done_after !== 1'b0)
                $display("FAIL rnd%0d_done: got %b%b%b exp 010", n, o_done_exec, o_done, o_done_after); else pass++;
            chk++; if (o_result !== ref_result || o_carry !== ref_carry)
                $display("FAIL rnd%0d_result: got %h c%b exp %h c%b", n, o_result, o_carry, ref_result, ref_carry); else pass++;
            chk++; if (o_rd !== ref_rf[d]) $display("FAIL rnd%0d_rd: got %h exp %h", n, o_rd, ref_rf[d]); else pass++;
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            chk++; if (rd_data !== ref_rf[i]) $display("FAIL rnd_final_r%0d: got %h exp %h", i, rd_data, ref_rf[i]); else pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_cmp();
        test_back_to_back();
        test_load_ignored();
        test_reset_abort();
        test_load_accept();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    // Backstop against a stuck run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", pass, chk);
        $fatal(1);
    end

endmodule
